memory_stage: RTL
=================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have a single clock and a reset that is asynchronous and active-high; ports: clk_i input 1 (rising-edge clock); rst_i input 1 (async active-high reset).
REQ-002 SHALL have inputs from execute: E_stat_i 3; E_icode_i 4; e_Cnd_i 1; e_valE_i 64; e_valA_i 64; e_dstE_i 4; e_dstM_i 4.
REQ-003 SHALL have input M_bubble_i 1, which inserts a bubble into the M register on its next load.
REQ-004 SHALL have registered outputs M_icode_o 4, M_Cnd_o 1, M_valE_o 64, M_valA_o 64, M_dstE_o 4, M_dstM_o 4 (the current M-register contents, forwarded to execute and decode).
REQ-005 SHALL have outputs m_valM_o 64 (memory read result), m_stat_o 3 (stage status) and mem_busy_o 1 (pipeline stall request).
REQ-006 SHALL have data-bus ports:
- outputs: dmem_req_o 1, dmem_we_o 1, dmem_addr_o 64, dmem_wdata_o 64;
- inputs: dmem_ack_i 1, dmem_rdata_i 64, dmem_err_i 1.

Function
REQ-007 SHALL load the M register from the execute inputs on a clock edge with mem_busy_o=0; with mem_busy_o=1 it SHALL hold (stall beats bubble).
REQ-008 SHALL load a bubble when M_bubble_i=1 and mem_busy_o=0: icode INOP, stat SAOK, Cnd 0, valE/valA 0, dstE/dstM RNONE.
REQ-009 SHALL classify the M-register operation as read for IMRMOVQ, IPOPQ and IRET, and as write for IRMMOVQ, IPUSHQ and ICALL; all other icodes make no access.
REQ-010 SHALL drive dmem_addr_o=M_valE for IRMMOVQ, IMRMOVQ, IPUSHQ and ICALL, and M_valA for IPOPQ and IRET; dmem_wdata_o=M_valA; dmem_we_o=1 only for write ops.
REQ-011 SHALL implement FSM states IDLE, REQ and DONE.
- IDLE: an access op with M stat SAOK -> mem_busy_o=1, next state REQ; otherwise mem_busy_o=0 and the state stays IDLE.
- REQ: dmem_req_o=1 and mem_busy_o=1, with addr, we and wdata stable; on dmem_ack_i=1, capture dmem_rdata_i (read only) and dmem_err_i, next state DONE.
- DONE: mem_busy_o=0 so the M register advances; next state IDLE.
REQ-012 SHALL accept an ack in the first REQ cycle, giving a minimum access latency of 3 cycles (IDLE, REQ, DONE); a non-access op SHALL take 1 cycle.
REQ-013 SHALL ignore dmem_ack_i outside REQ; dmem_req_o SHALL be 0 in IDLE and DONE.
REQ-014 SHALL drive m_valM_o with the captured read data in DONE for read ops, and 0 otherwise.
REQ-015 SHALL drive m_stat_o=SADR in DONE when the captured err=1; otherwise m_stat_o=M stat.
REQ-016 SHALL issue no bus request when M stat is not SAOK (SHLT, SADR, SINS); that status SHALL pass through in 1 cycle.
REQ-017 SHALL clear the captured data and err when the state returns to IDLE.

Reset
REQ-018 SHALL, on rst_i=1, immediately and regardless of clock:
- set the M register to bubble;
- set the FSM to IDLE;
- set captured data and err to 0;
- drive dmem_req_o=0, mem_busy_o=0, m_valM_o=0 and m_stat_o=SAOK.
REQ-019 SHALL abandon an in-flight access on reset mid-REQ; an ack arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-020 SHALL, when DMEM_ALIGN_CHECK_EN is defined, treat an access op with dmem_addr_o[2:0]!=0 as faulting: no dmem_req_o, FSM stays IDLE, mem_busy_o=0, m_stat_o=SADR in the same cycle.
REQ-021 SHALL, when DMEM_ALIGN_CHECK_EN is undefined, issue all addresses unchanged, with no alignment check.

Verification
REQ-022 SHALL cover this case: IMRMOVQ, valE=0x100, ack on the 2nd REQ cycle with rdata=0xDEAD -> req high for 2 cycles, addr=0x100, we=0, busy for 3 cycles, then DONE with m_valM_o=0xDEAD and m_stat_o=SAOK.
REQ-023 SHALL cover this case: IPUSHQ, valE=0x1F8, valA=0x55, ack immediate -> we=1, addr=0x1F8, wdata=0x55, m_valM_o=0, total 3 cycles.
REQ-024 SHALL cover this case: IOPQ followed by M_bubble_i=1 -> no req, busy 0, M_icode_o=INOP and M_dstE_o=0xF after the edge.
REQ-025 SHALL cover this case: IRET, valA=0x20, ack with dmem_err_i=1 -> m_stat_o=SADR in DONE; a following SHLT instruction passes with no req.
REQ-026 SHALL cover this case: rst_i pulsed mid-REQ, then ack after release -> req drops asynchronously, FSM IDLE, the late ack is ignored and the M register holds a bubble.
REQ-027 SHALL cover this case: with DMEM_ALIGN_CHECK_EN defined, IMRMOVQ with valE=0x103 -> no req, m_stat_o=SADR, busy 0; with the macro undefined -> req issued with addr=0x103.

Source files
------------

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - data-memory bus between the memory stage and the data memory
// The memory stage is the master; the memory (or its model) is the slave.
interface memory_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [63:0] dmem_rdata_i;
  logic        dmem_err_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i, dmem_err_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i, dmem_err_i
  );
endinterface

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 memory stage: M pipeline register plus request/ack data-bus FSM
// Optional DMEM_ALIGN_CHECK_EN: misaligned accesses fault with SADR instead of reaching the bus.
module memory_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  E_stat_i,
  input  logic [3:0]  E_icode_i,
  input  logic        e_Cnd_i,
  input  logic [63:0] e_valE_i,
  input  logic [63:0] e_valA_i,
  input  logic [3:0]  e_dstE_i,
  input  logic [3:0]  e_dstM_i,
  input  logic        M_bubble_i,
  output logic [3:0]  M_icode_o,
  output logic        M_Cnd_o,
  output logic [63:0] M_valE_o,
  output logic [63:0] M_valA_o,
  output logic [3:0]  M_dstE_o,
  output logic [3:0]  M_dstM_o,
  output logic [63:0] m_valM_o,
  output logic [2:0]  m_stat_o,
  output logic        mem_busy_o,
  memory_stage_if.master dmem
);
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SADR    = 3'd2;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [2:0]  M_stat;
  logic [63:0] cap_data;
  logic        cap_err;
  logic        is_read, is_write, is_access, misaligned, start;

  assign is_read   = (M_icode_o == IMRMOVQ) || (M_icode_o == IPOPQ) || (M_icode_o == IRET);
  assign is_write  = (M_icode_o == IRMMOVQ) || (M_icode_o == IPUSHQ) || (M_icode_o == ICALL);
  assign is_access = is_read || is_write;

  // Pops and returns read through the stack pointer carried in valA.
  assign dmem.dmem_addr_o  = ((M_icode_o == IPOPQ) || (M_icode_o == IRET)) ? M_valA_o : M_valE_o;
  assign dmem.dmem_wdata_o = M_valA_o;
  assign dmem.dmem_we_o    = is_write;
  assign dmem.dmem_req_o   = (state == REQ);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = is_access && (M_stat == SAOK) && (dmem.dmem_addr_o[2:0] != 3'd0);
`else
  assign misaligned = 1'b0;
`endif

  assign start      = is_access && (M_stat == SAOK) && !misaligned;
  assign mem_busy_o = ((state == IDLE) && start) || (state == REQ);
  assign m_valM_o   = ((state == DONE) && is_read) ? cap_data : 64'd0;
  assign m_stat_o   = (((state == DONE) && cap_err) || misaligned) ? SADR : M_stat;

  // Stall wins over bubble: the M register only moves when the bus is quiet.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      M_stat    <= SAOK;
      M_icode_o <= INOP;
      M_Cnd_o   <= 1'b0;
      M_valE_o  <= 64'd0;
      M_valA_o  <= 64'd0;
      M_dstE_o  <= RNONE;
      M_dstM_o  <= RNONE;
    end else if (!mem_busy_o) begin
      if (M_bubble_i) begin
        M_stat    <= SAOK;
        M_icode_o <= INOP;
        M_Cnd_o   <= 1'b0;
        M_valE_o  <= 64'd0;
        M_valA_o  <= 64'd0;
        M_dstE_o  <= RNONE;
        M_dstM_o  <= RNONE;
      end else begin
        M_stat    <= E_stat_i;
        M_icode_o <= E_icode_i;
        M_Cnd_o   <= e_Cnd_i;
        M_valE_o  <= e_valE_i;
        M_valA_o  <= e_valA_i;
        M_dstE_o  <= e_dstE_i;
        M_dstM_o  <= e_dstM_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cap_data <= 64'd0;
      cap_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= REQ;
        REQ: begin
          if (dmem.dmem_ack_i) begin
            cap_data <= is_read ? dmem.dmem_rdata_i : 64'd0;
            cap_err  <= dmem.dmem_err_i;
            state    <= DONE;
          end
        end
        DONE: begin
          cap_data <= 64'd0;
          cap_err  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
